// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// registers the IF/ID latch, with stall, redirect and end-of-program halt.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 30,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_instr_o,
    output logic        id_valid_o,
    output logic        misalign_o,
    output logic        halted_o
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } state_e;

    localparam logic [31:0] LAST_PC = 32'(4 * (ROM_WORDS - 1));
    localparam logic [31:0] END_PC  = 32'(4 * ROM_WORDS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic        misalign_q, misalign_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Redirect outranks stall; stall freezes everything except the misalign pulse.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        misalign_d = 1'b0;

        if (redirect_i) begin
            pc_d       = {redirect_pc_i[31:2], 2'b00};
            id_pc_d    = '0;
            id_pc4_d   = '0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
            state_d    = S_RUN;
            misalign_d = |redirect_pc_i[1:0];
        end else if (!stall_i) begin
            id_pc_d    = '0;
            id_pc4_d   = '0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
            case (state_q)
                S_BOOT: state_d = S_RUN;
                S_RUN: begin
                    if (pc_q < END_PC) begin
                        id_pc_d    = pc_q;
                        id_pc4_d   = pc_q + 32'd4;
                        id_instr_d = imem_instr_i;
                        id_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        if (pc_q == LAST_PC) state_d = S_HALT;
                    end else begin
                        state_d = S_HALT;
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_BOOT;
            endcase
        end
    end

    assign imem_pc_o  = pc_q;
    assign id_pc_o    = id_pc_q;
    assign id_pc4_o   = id_pc4_q;
    assign id_instr_o = id_instr_q;
    assign id_valid_o = id_valid_q;
    assign misalign_o = misalign_q;
    assign halted_o   = (state_q == S_HALT);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table for fetch/stall/redirect, plus
// hand sequences for end-of-program halt and asynchronous reset.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_pc, imem_instr;
    logic [31:0] id_pc, id_pc4, id_instr;
    logic        id_valid, misalign, halted;

    int errors = 0;
    int checks = 0;

    logic [31:0] rom [30];

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .ROM_WORDS(30),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_pc_o    (imem_pc),
        .imem_instr_i (imem_instr),
        .id_pc_o      (id_pc),
        .id_pc4_o     (id_pc4),
        .id_instr_o   (id_instr),
        .id_valid_o   (id_valid),
        .misalign_o   (misalign),
        .halted_o     (halted)
    );

    function automatic logic [31:0] word(int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    always_comb begin
        imem_instr = 32'h0;
        if (imem_pc[31:2] < 30) imem_instr = rom[imem_pc[6:2]];
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_all(string tag, logic [31:0] pc, logic [31:0] ipc, logic [31:0] ipc4,
                              logic [31:0] instr, logic valid, logic mis, logic halt);
        chk({tag, ".imem_pc"}, imem_pc, pc);
        chk({tag, ".id_pc"}, id_pc, ipc);
        chk({tag, ".id_pc4"}, id_pc4, ipc4);
        chk({tag, ".id_instr"}, id_instr, instr);
        chk({tag, ".id_valid"}, 32'(id_valid), 32'(valid));
        chk({tag, ".misalign"}, 32'(misalign), 32'(mis));
        chk({tag, ".halted"}, 32'(halted), 32'(halt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] instr;
        logic        valid;
        logic        mis;
        logic        halt;
    } vec_t;

    function automatic vec_t mk(logic s, logic r, logic [31:0] rpc, logic [31:0] pc,
                                logic [31:0] ipc, logic [31:0] ipc4, logic [31:0] instr,
                                logic v, logic m, logic h);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rpc; t.pc = pc; t.ipc = ipc; t.ipc4 = ipc4;
        t.instr = instr; t.valid = v; t.mis = m; t.halt = h;
        return t;
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        vec_t vecs [13];
        for (int i = 0; i < 30; i++) rom[i] = word(i);

        vecs[0]  = mk(0, 0, 0,     32'h00, 32'h00, 32'h00, NOP,      0, 0, 0);
        vecs[1]  = mk(0, 0, 0,     32'h04, 32'h00, 32'h04, word(0),  1, 0, 0);
        vecs[2]  = mk(0, 0, 0,     32'h08, 32'h04, 32'h08, word(1),  1, 0, 0);
        vecs[3]  = mk(1, 0, 0,     32'h08, 32'h04, 32'h08, word(1),  1, 0, 0);
        vecs[4]  = mk(1, 0, 0,     32'h08, 32'h04, 32'h08, word(1),  1, 0, 0);
        vecs[5]  = mk(1, 0, 0,     32'h08, 32'h04, 32'h08, word(1),  1, 0, 0);
        vecs[6]  = mk(0, 0, 0,     32'h0C, 32'h08, 32'h0C, word(2),  1, 0, 0);
        vecs[7]  = mk(0, 0, 0,     32'h10, 32'h0C, 32'h10, word(3),  1, 0, 0);
        vecs[8]  = mk(1, 1, 32'h40, 32'h40, 32'h00, 32'h00, NOP,     0, 0, 0);
        vecs[9]  = mk(0, 0, 0,     32'h44, 32'h40, 32'h44, word(16), 1, 0, 0);
        vecs[10] = mk(0, 1, 32'h22, 32'h20, 32'h00, 32'h00, NOP,     0, 1, 0);
        vecs[11] = mk(0, 0, 0,     32'h24, 32'h20, 32'h24, word(8),  1, 0, 0);
        vecs[12] = mk(0, 0, 0,     32'h28, 32'h24, 32'h28, word(9),  1, 0, 0);

        #12;
        expect_all("reset", 32'h0, 32'h0, 32'h0, NOP, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            stall       = vecs[i].stall;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            step();
            expect_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ipc, vecs[i].ipc4,
                       vecs[i].instr, vecs[i].valid, vecs[i].mis, vecs[i].halt);
        end
        stall = 1'b0;
        redirect = 1'b0;

        // Run off the end of the ROM: words 28, 29 then halt.
        redirect = 1'b1;
        redirect_pc = 32'h70;
        step();
        redirect = 1'b0;
        expect_all("end_redir", 32'h70, 32'h0, 32'h0, NOP, 0, 0, 0);
        step();
        expect_all("end_w28", 32'h74, 32'h70, 32'h74, word(28), 1, 0, 0);
        step();
        expect_all("end_w29", 32'h78, 32'h74, 32'h78, word(29), 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_all($sformatf("halt%0d", i), 32'h78, 32'h0, 32'h0, NOP, 0, 0, 1);
        end

        // Redirect past the ROM: one bubble in RUN, then halt with PC held.
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        expect_all("oob_redir", 32'h200, 32'h0, 32'h0, NOP, 0, 0, 0);
        step();
        expect_all("oob_halt", 32'h200, 32'h0, 32'h0, NOP, 0, 0, 1);
        step();
        expect_all("oob_hold", 32'h200, 32'h0, 32'h0, NOP, 0, 0, 1);

        redirect = 1'b1;
        redirect_pc = 32'h0;
        step();
        redirect = 1'b0;
        expect_all("resume", 32'h0, 32'h0, 32'h0, NOP, 0, 0, 0);
        step();
        expect_all("refetch0", 32'h4, 32'h0, 32'h4, word(0), 1, 0, 0);
        step();
        expect_all("refetch1", 32'h8, 32'h4, 32'h8, word(1), 1, 0, 0);

        // Asynchronous reset between edges while stall and redirect are both high.
        #2;
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h41;
        rst_n = 1'b0;
        #1;
        expect_all("async_rst", 32'h0, 32'h0, 32'h0, NOP, 0, 0, 0);
        step();
        expect_all("rst_held", 32'h0, 32'h0, 32'h0, NOP, 0, 0, 0);
        @(negedge clk);
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        rst_n = 1'b1;
        step();
        expect_all("reboot", 32'h0, 32'h0, 32'h0, NOP, 0, 0, 0);
        step();
        expect_all("reboot_f0", 32'h4, 32'h0, 32'h4, word(0), 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
